// File: rtl/sm_regdump_uart.sv
// Debug register dump engine: walks debug addresses 0..31 and streams a
// 0xA5-headed, big-endian word dump over an 8N1 UART transmitter.
module sm_regdump_uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic        hold
);

  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [4:0] LAST_ADDR = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_WORD, S_FIN} state_e;
  typedef enum logic [1:0] {P_START, P_DATA, P_STOP} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [4:0]          addr_q, addr_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [7:0]          cur_byte_c;
  logic [2:0]          bit_idx_nxt_c;
  logic                baud_last_c;

  // Byte currently on the line: header, or the selected word byte (MSB first)
  always_comb begin
    cur_byte_c = HDR_BYTE;
    if (state_q == S_WORD) begin
      case (byte_idx_q)
        2'd0:    cur_byte_c = word_q[31:24];
        2'd1:    cur_byte_c = word_q[23:16];
        2'd2:    cur_byte_c = word_q[15:8];
        default: cur_byte_c = word_q[7:0];
      endcase
    end
  end

  assign baud_last_c   = (baud_q == BAUD_LAST);
  assign bit_idx_nxt_c = bit_idx_q + 3'd1;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        // FIN doubles as the one idle cycle, so start is honoured here too
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        addr_d  = '0;
        if (start) begin
          state_d    = S_HDR;
          phase_d    = P_START;
          bit_idx_d  = '0;
          baud_d     = '0;
          byte_idx_d = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_HDR, S_WORD: begin
        baud_d = baud_last_c ? '0 : baud_q + BAUD_W'(1);

        if (state_q == S_WORD && phase_q == P_START && byte_idx_q == 2'd0 && baud_q == '0) begin
          word_d = regData;
        end

        if (baud_last_c) begin
          case (phase_q)
            P_START: begin
              phase_d   = P_DATA;
              bit_idx_d = '0;
              tx_d      = cur_byte_c[0];
            end
            P_DATA: begin
              if (bit_idx_q == 3'd7) begin
                phase_d = P_STOP;
                tx_d    = 1'b1;
              end else begin
                bit_idx_d = bit_idx_nxt_c;
                tx_d      = cur_byte_c[bit_idx_nxt_c];
              end
            end
            P_STOP: begin
              phase_d = P_START;
              tx_d    = 1'b0;
              if (state_q == S_HDR) begin
                state_d    = S_WORD;
                byte_idx_d = '0;
              end else if (byte_idx_q != 2'd3) begin
                byte_idx_d = byte_idx_q + 2'd1;
              end else if (addr_q == LAST_ADDR) begin
                state_d = S_FIN;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                addr_d  = '0;
              end else begin
                addr_d     = addr_q + 5'd1;
                byte_idx_d = '0;
              end
            end
            default: phase_d = P_START;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= P_START;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign regAddr = addr_q;
  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hold    = busy_q;

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: frame waveform, byte decode and address timing
// compared against a register-file model of the expected dump.
module tb_sm_regdump_uart;

  localparam int CPB       = 4;
  localparam int BYTE_CYC  = 10 * CPB;
  localparam int FRAME_CYC = 129 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        uart_tx, busy, done, hold;

  logic [31:0] regs [32];
  int n_checks = 0;
  int n_fail   = 0;
  bit aborted;

  always #5 clk = ~clk;

  always_comb reg_data = regs[reg_addr];

  sm_regdump_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .regAddr (reg_addr),
    .regData (reg_data),
    .uart_tx (uart_tx),
    .busy    (busy),
    .done    (done),
    .hold    (hold)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected byte b of the frame: header, then each word big-endian
  function automatic logic [7:0] exp_byte(input int b);
    logic [31:0] w;
    int r;
    if (b == 0) return 8'hA5;
    w = regs[(b - 1) / 4];
    r = (b - 1) % 4;
    return w[8 * (3 - r) +: 8];
  endfunction

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  task automatic idle_check(input int n, input string tag);
    int err;
    err = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0 || hold !== 1'b0 || done !== 1'b0 || uart_tx !== 1'b1 || reg_addr !== 5'd0)
        err++;
    end
    chk(tag, 32'(err), 32'd0);
  endtask

  // Caller has driven start=1 at a negedge; runs one frame and its done cycle
  task automatic frame_check(input int abort_at, input bit hold_start,
                             input bit ignore_pulses, output bit was_aborted);
    int wave_err, ctl_err, addr_err, chg;
    logic [4:0] prev_addr;
    logic [7:0] rx;
    was_aborted = 1'b0;
    wave_err = 0; ctl_err = 0; addr_err = 0; chg = 0;
    rx = '0;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    prev_addr = reg_addr;
    for (int k = 0; k < FRAME_CYC; k++) begin
      int b, j, ph;
      logic       exp_tx;
      logic [7:0] eb;
      logic [4:0] exp_a;
      b  = k / BYTE_CYC;
      j  = (k % BYTE_CYC) / CPB;
      ph = k % CPB;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_hold", {30'd0, done, hold}, 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        was_aborted = 1'b1;
        return;
      end
      eb     = exp_byte(b);
      exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[j - 1];
      exp_a  = (b == 0) ? 5'd0 : 5'((b - 1) / 4);
      if (uart_tx !== exp_tx) wave_err++;
      if (busy !== 1'b1 || hold !== 1'b1 || done !== 1'b0) ctl_err++;
      if (reg_addr !== exp_a) addr_err++;
      if (k > 0 && reg_addr !== prev_addr) chg++;
      prev_addr = reg_addr;
      if (b > 0 && (b - 1) % 4 == 0 && j == 0 && ph == 0)
        chk("cap_addr", 32'(reg_addr), 32'(exp_a));
      if (ph == CPB / 2) begin
        if (j >= 1 && j <= 8) rx[j - 1] = uart_tx;
        if (j == 9) chk("rx_byte", 32'(rx), 32'(eb));
      end
      if (ignore_pulses) start = (k == 100 || k == 3000);
      @(negedge clk);
    end
    chk("tx_wave_err", 32'(wave_err), 32'd0);
    chk("busy_ctl_err", 32'(ctl_err), 32'd0);
    chk("addr_err", 32'(addr_err), 32'd0);
    chk("addr_changes", 32'(chg), 32'd31);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", {30'd0, busy, hold}, 32'd0);
    chk("done_tx", 32'(uart_tx), 32'd1);
  endtask

  initial begin
    regs[0] = 32'h0000_0040;
    for (int i = 1; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(uart_tx), 32'd1);
    chk("reset_ctl", {29'd0, busy, done, hold}, 32'd0);
    chk("reset_addr", 32'(reg_addr), 32'd0);
    rst_n = 1'b1;
    idle_check(100, "idle_after_reset");

    // Full dump with the fixed pattern
    start = 1'b1;
    frame_check(-1, 1'b0, 1'b0, aborted);
    idle_check(int'($urandom_range(5, 20)), "idle_after_frame");

    // Start pulses during busy are ignored
    rand_regs();
    start = 1'b1;
    frame_check(-1, 1'b0, 1'b1, aborted);
    idle_check(50, "no_extra_frame");

    // Start held: back-to-back frames with a single idle (done) cycle
    rand_regs();
    start = 1'b1;
    frame_check(-1, 1'b1, 1'b0, aborted);
    rand_regs();
    frame_check(-1, 1'b1, 1'b0, aborted);
    rand_regs();
    frame_check(-1, 1'b0, 1'b0, aborted);
    idle_check(10, "idle_after_b2b");

    // Reset during word 7, byte 2, then a fresh frame
    rand_regs();
    start = 1'b1;
    frame_check(31 * BYTE_CYC + int'($urandom_range(0, BYTE_CYC - 1)), 1'b0, 1'b0, aborted);
    chk("aborted", 32'(aborted), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_check(30, "idle_after_abort");
    rand_regs();
    start = 1'b1;
    frame_check(-1, 1'b0, 1'b0, aborted);
    idle_check(10, "idle_final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
